// File: rtl/commit_trace_if.sv
// Trace record stream from commit_trace_buffer to a debug/testbench sink.
// master = record producer (the buffer), slave = sink.
interface commit_trace_if #(
  parameter int ENTRY_W = 81
) ();
  logic               trace_valid;
  logic               trace_ready;
  logic [ENTRY_W-1:0] trace_data;

  modport master (output trace_valid, output trace_data, input trace_ready);
  modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/commit_trace_buffer.sv
// Packs core retirement events into trace records, queues them in a FIFO and drains over a stream.
// Optional macro TRACE_TIMESTAMP_EN prepends a 16-bit free-running cycle stamp to each record.
module commit_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_en,
  input  logic                  RegWriteSignal,
  input  logic [4:0]            RegNum,
  input  logic [31:0]           RegData,
  input  logic                  WriteEnable,
  input  logic                  ReadEnable,
  input  logic [8:0]            Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData,
  commit_trace_if.master        trace,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  overflow,
  input  logic                  overflow_clr
);
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif
  localparam int BODY_W  = 49 + DATA_WIDTH;
  localparam int ENTRY_W = BODY_W + TS_W;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic                  rw, mw, mr;
  logic                  push_req, push_ok, pop, drop;
  logic [DATA_WIDTH-1:0] mdata;
  logic [BODY_W-1:0]     rec_body;
  logic [ENTRY_W-1:0]    rec;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;

  // x0 writes are architecturally invisible, so they do not count as events
  assign rw       = RegWriteSignal & (RegNum != 5'd0);
  assign mw       = WriteEnable;
  assign mr       = ReadEnable;
  assign push_req = trace_en & (rw | mw | mr);

  always_comb begin
    mdata = '0;
    if (mw)      mdata = WriteData;
    else if (mr) mdata = ReadData;
  end

  assign rec_body = {rw, mw, mr,
                     rw ? RegNum : 5'd0,
                     (mw | mr) ? Address : 9'd0,
                     rw ? RegData : 32'd0,
                     mdata};

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;
  always_ff @(posedge clk) begin
    if (rst) ts <= 16'd0;
    else     ts <= ts + 16'd1;
  end
  assign rec = {ts, rec_body};
`else
  assign rec = rec_body;
`endif

  assign trace.trace_valid = (count != '0);
  assign trace.trace_data  = mem[rd_ptr];
  assign pop               = trace.trace_valid & trace.trace_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push_ok           = push_req & ((count != FULL) | pop);
  assign drop              = push_req & ~push_ok;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  // A drop in the clearing cycle wins over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)     drop_count <= CNT_WIDTH'(1);
      else if (!(&drop_count)) drop_count <= drop_count + CNT_WIDTH'(1);
    end else if (overflow_clr) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: directed events queue expected records, a monitor checks drains.
module tb_commit_trace_buffer;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif
  localparam int DW = 32;
  localparam int EW = 49 + DW + TS_W;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          trace_en, rws, we, re, clr;
  logic [4:0]    rn;
  logic [31:0]   rd;
  logic [8:0]    addr;
  logic [DW-1:0] wd, rdd;
  logic [CW-1:0] drop_count;
  logic          overflow;
  logic [15:0]   ts_m;

  commit_trace_if #(.ENTRY_W(EW)) tif ();

  commit_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .RegWriteSignal(rws), .RegNum(rn), .RegData(rd),
    .WriteEnable(we), .ReadEnable(re), .Address(addr),
    .WriteData(wd), .ReadData(rdd),
    .trace(tif.master),
    .drop_count(drop_count), .overflow(overflow), .overflow_clr(clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ts_m <= rst ? 16'd0 : ts_m + 16'd1;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] sb [$];

  function automatic logic [EW-1:0] mk(input logic [2:0] f, input logic [4:0] n, input logic [8:0] a,
                                       input logic [31:0] r, input logic [31:0] m, input logic [15:0] t);
    logic [EW-TS_W-1:0] body;
    body = {f, n, a, r, m};
`ifdef TRACE_TIMESTAMP_EN
    mk = {t, body};
`else
    mk = body ^ EW'(t & 16'h0);
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rws = 0; rn = 0; rd = 0; we = 0; re = 0; addr = 0; wd = 0; rdd = 0;
  endtask

  // One event cycle; exp says whether the bench expects the record to be queued
  task automatic ev(input logic r_s, input logic [4:0] n, input logic [31:0] r_d, input logic w_e,
                    input logic r_e, input logic [8:0] a, input logic [31:0] w_d, input logic [31:0] r_dd,
                    input bit exp, input logic [EW-1:0] rec);
    rws = r_s; rn = n; rd = r_d; we = w_e; re = r_e; addr = a; wd = w_d; rdd = r_dd;
    if (exp) sb.push_back(rec);
    cyc();
    idle_in();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 64) begin cyc(); n++; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s drain timeout: %0d records still expected", name, sb.size());
    end
  endtask

  // Monitor: compare every accepted head record against the scoreboard; check hold stability
  initial begin
    logic          hold;
    logic [EW-1:0] held, exp;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else begin
        if (hold && tif.trace_valid) begin
          checks++;
          if (tif.trace_data !== held) begin
            failures++;
            $display("FAIL hold_stable: got %0h expected %0h", tif.trace_data, held);
          end
        end
        if (tif.trace_valid && tif.trace_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_record: got %0h expected none", tif.trace_data);
          end else begin
            exp = sb.pop_front();
            if (tif.trace_data !== exp) begin
              failures++;
              $display("FAIL record: got %0h expected %0h", tif.trace_data, exp);
            end
          end
        end
        hold = tif.trace_valid & ~tif.trace_ready;
        held = tif.trace_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [EW-1:0] r;
    rst = 1; trace_en = 1; clr = 0; tif.trace_ready = 1; idle_in();
    cyc(); cyc();
    rst = 0;
    chk("reset_valid", 128'(tif.trace_valid), 128'd0);
    chk("reset_drop", 128'(drop_count), 128'd0);
    chk("reset_ovf", 128'(overflow), 128'd0);

    // register write, one-cycle latency into an empty FIFO
    r = mk(3'b100, 5'd5, 9'd0, 32'h0000_00AA, 32'd0, ts_m);
    ev(1, 5'd5, 32'hAA, 0, 0, 9'h0, 32'h0, 32'h0, 1, r);
    chk("latency_valid", 128'(tif.trace_valid), 128'd1);
    chk("latency_data", 128'(tif.trace_data), 128'(r));

    // store with stray RegNum/RegData must zero the register fields
    ev(0, 5'd7, 32'h5555_5555, 1, 0, 9'h1F4, 32'hDEAD_BEEF, 32'h1111, 1,
       mk(3'b010, 5'd0, 9'h1F4, 32'd0, 32'hDEAD_BEEF, ts_m));
    // load: one record with both reg write and read
    ev(1, 5'd3, 32'h1234, 0, 1, 9'h010, 32'hFFFF_0000, 32'h1234, 1,
       mk(3'b101, 5'd3, 9'h010, 32'h1234, 32'h1234, ts_m));
    // x0 write and disabled capture produce nothing
    ev(1, 5'd0, 32'hCAFE, 0, 0, 9'h0, 32'h0, 32'h0, 0, '0);
    trace_en = 0;
    ev(1, 5'd9, 32'hCAFE, 1, 1, 9'h055, 32'h77, 32'h88, 0, '0);
    trace_en = 1;
    chk("no_record_valid", 128'(tif.trace_valid), 128'd0);
    chk("no_record_drop", 128'(drop_count), 128'd0);
    // store and load together: store data wins
    ev(0, 5'd0, 32'h0, 1, 1, 9'h0AB, 32'hA5A5_0001, 32'h5A5A_0002, 1,
       mk(3'b011, 5'd0, 9'h0AB, 32'd0, 32'hA5A5_0001, ts_m));
    drain("basic");

    // fill with sink stalled, then overflow
    tif.trace_ready = 0;
    for (int i = 0; i < 16; i++)
      ev(1, 5'(i + 1), 32'(i), 0, 0, 9'h0, 32'h0, 32'h0, 1,
         mk(3'b100, 5'(i + 1), 9'd0, 32'(i), 32'd0, ts_m));
    for (int i = 0; i < 3; i++) ev(0, 5'd0, 32'h0, 1, 0, 9'h1, 32'hBAD, 32'h0, 0, '0);
    chk("full_drop3", 128'(drop_count), 128'd3);
    chk("full_ovf", 128'(overflow), 128'd1);
    clr = 1; cyc(); clr = 0;
    chk("clr_drop", 128'(drop_count), 128'd0);
    chk("clr_ovf", 128'(overflow), 128'd0);
    clr = 1;
    ev(0, 5'd0, 32'h0, 0, 1, 9'h2, 32'h0, 32'hBAD, 0, '0);
    clr = 0;
    chk("clr_vs_drop_cnt", 128'(drop_count), 128'd1);
    chk("clr_vs_drop_ovf", 128'(overflow), 128'd1);
    for (int i = 0; i < 15; i++) ev(0, 5'd0, 32'h0, 1, 0, 9'h3, 32'h0, 32'h0, 0, '0);
    chk("drop_saturate", 128'(drop_count), 128'd15);
    // full with a pop in the same cycle accepts the push
    tif.trace_ready = 1;
    ev(1, 5'd31, 32'hFEED_0017, 0, 0, 9'h0, 32'h0, 32'h0, 1,
       mk(3'b100, 5'd31, 9'd0, 32'hFEED_0017, 32'd0, ts_m));
    chk("full_pop_no_drop", 128'(drop_count), 128'd15);
    drain("full");

    // reset while records are pending
    tif.trace_ready = 0;
    for (int i = 0; i < 5; i++)
      ev(0, 5'd0, 32'h0, 1, 0, 9'(i), 32'(100 + i), 32'h0, 1,
         mk(3'b010, 5'd0, 9'(i), 32'd0, 32'(100 + i), ts_m));
    tif.trace_ready = 1;
    cyc();
    rst = 1;
    sb.delete();
    ev(1, 5'd4, 32'h44, 0, 0, 9'h0, 32'h0, 32'h0, 0, '0);
    rst = 0;
    chk("midreset_valid", 128'(tif.trace_valid), 128'd0);
    chk("midreset_drop", 128'(drop_count), 128'd0);
    chk("midreset_ovf", 128'(overflow), 128'd0);
    repeat (4) cyc();
    ev(1, 5'd9, 32'h55, 0, 0, 9'h0, 32'h0, 32'h0, 1,
       mk(3'b100, 5'd9, 9'd0, 32'h55, 32'd0, 16'd4));
    drain("post_reset");

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
